fifo_read_arb: RTL and testbench
================================

Name: fifo_read_arb

Overview:
- Parametrised successor to the 8-channel read mux of the SyncFIFO read path.
- Arbitrates CH_NUM channel read requests onto the single FIFO read port using registered round-robin ownership.
- Adds per-grant burst limiting, empty gating, peek (rd_only) handling and a registered busy flag.
- Sits between the channel masters and the SyncFIFO core read interface.

Parameters:
- CH_NUM, 8, number of requesting channels (≥2).
- CH_W, $clog2(CH_NUM), width of channel index.
- MAX_BURST, 4, max popping beats per grant (≥1).
- BC_W, $clog2(MAX_BURST+1), burst counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- block  in  CH_NUM  per-channel block request; any bit stalls reads.
- rd_req  in  CH_NUM  per-channel read request (level).
- rd_only_i  in  CH_NUM  per-channel peek qualifier (read without pop).
- empty  in  1  FIFO empty flag.
- rd_en  out  1  FIFO read enable.
- rd_only  out  1  FIFO read-only (peek) qualifier.
- grant  out  CH_NUM  one-hot owner, registered.
- grant_id  out  CH_W  binary owner index, registered.
- grant_vld  out  1  ownership valid.
- rd_ack  out  CH_NUM  one-hot, equals grant when rd_en=1, else 0.
- burst_done  out  1  one-cycle pulse on grant release.
- busy  out  1  registered OR of block.

Behaviour:
- Reset (async, rst=1) values:
  - State IDLE.
  - grant=0, grant_id=0, grant_vld=0.
  - Round-robin pointer=0, burst counter=0.
  - busy=0, burst_done=0.
  - rd_en=0, rd_only=0, rd_ack=0.
- Reset mid-operation drops ownership immediately; no beat completes.
- busy: registered `|block`, 1-cycle latency.
- stall = `|block` OR busy. Block lasts at least 2 cycles in effect.
- State IDLE:
  - If !stall and `|rd_req`: select first requester at or after pointer, wrapping CH_NUM-1→0.
  - Next edge: grant, grant_id, grant_vld=1; state OWN; counter=0.
  - No rd_en in IDLE.
- State OWN (owner = grant_id):
  - Combinational rd_en = rd_req[owner] & !empty & !stall.
  - Combinational rd_only = rd_en & rd_only_i[owner].
  - Popping beat (rd_en & !rd_only) increments counter. Peek beats do not count.
  - empty or stall: rd_en=0; owner retained; counter held.
  - Release when rd_req[owner]=0, or a popping beat makes counter==MAX_BURST.
  - On release, next edge:
    - state IDLE, grant=0, grant_vld=0.
    - pointer = (owner+1) mod CH_NUM.
    - burst_done=1 for that one cycle.
  - One IDLE bubble between grants is mandatory.
- Simultaneous events:
  - Release and a new request in the same cycle: the request is arbitrated in the following IDLE cycle.
  - Block asserted in the same cycle as a beat: the beat is suppressed.
- A request that drops while not owned has no effect.
- Fairness: each continuously requesting channel is granted within CH_NUM grants.
- rd_en never asserts when empty=1, grant_vld=0, or stall=1.
- grant is always one-hot or zero.

Decomposition:
- Shared package fifo_pkg holds:
  - State encoding ST_IDLE/ST_OWN.
  - Default CH_NUM/MAX_BURST constants.
  - One-hot↔index conversion functions.
- Sub-module rr_arbiter (parametrised CH_NUM) contains only the rotating-priority combinational pick from req and pointer. It outputs a one-hot winner and its index.
- FSM, counter, registers and gating live in fifo_read_arb.

Test Plan (CH_NUM=8, MAX_BURST=4):
- Reset during OWN with rd_en=1 → all outputs 0 same cycle; after release, first grant goes to lowest requester from pointer 0.
- rd_req=8'h01, empty=0, held → grant 8'h01 after 1 cycle; 4 rd_en beats; burst_done pulse; 1 idle cycle; re-grant ch0.
- rd_req=8'h81 held, pointer 0 → grants alternate ch0, ch7, ch0; each gets 4 beats; rd_ack matches grant on beats.
- ch3 owns, empty=1 for 3 cycles mid-burst → rd_en=0 for those cycles; grant held; burst resumes and completes with 4 popping beats total.
- block[5] pulsed 1 cycle during OWN → rd_en=0 that cycle and the next (busy=1); busy falls 1 cycle after block.
- ch2 owns with rd_only_i[2]=1 for 2 beats, then 0 → rd_only=1 on the first 2 beats; release after 4 further popping beats (6 rd_en total).

Source files
------------

// File: rtl/fifo_read_arb_pkg.sv
// Shared types, default sizes and one-hot/index helpers for the FIFO read arbiter.
package fifo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  localparam int unsigned CH_NUM_DEF    = 8;
  localparam int unsigned MAX_BURST_DEF = 4;

  // Helpers work on a fixed 32-channel span; callers cast to their own width.
  localparam int unsigned CH_MAX   = 32;
  localparam int unsigned CH_IDX_W = 5;

  // Binary index to one-hot vector.
  function automatic logic [CH_MAX-1:0] idx2oh(input logic [CH_IDX_W-1:0] idx);
    return CH_MAX'(1) << idx;
  endfunction

  // One-hot vector to binary index (OR-reduction, assumes at most one bit set).
  function automatic logic [CH_IDX_W-1:0] oh2idx(input logic [CH_MAX-1:0] oh);
    logic [CH_IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < CH_MAX; i++) begin
      if (oh[i]) r = r | CH_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_read_arb_if.sv
// Channel-side and FIFO-side signals of the read arbiter, bundled as one bus.
interface fifo_read_arb_if
  import fifo_pkg::*;
#(
  parameter int unsigned CH_NUM = CH_NUM_DEF,
  parameter int unsigned CH_W   = $clog2(CH_NUM)
);
  logic [CH_NUM-1:0] block;
  logic [CH_NUM-1:0] rd_req;
  logic [CH_NUM-1:0] rd_only_i;
  logic              empty;
  logic              rd_en;
  logic              rd_only;
  logic [CH_NUM-1:0] grant;
  logic [CH_W-1:0]   grant_id;
  logic              grant_vld;
  logic [CH_NUM-1:0] rd_ack;
  logic              burst_done;
  logic              busy;

  // Requesters and FIFO flags drive this side.
  modport master (
    output block, rd_req, rd_only_i, empty,
    input  rd_en, rd_only, grant, grant_id, grant_vld, rd_ack, burst_done, busy
  );

  // The arbiter itself.
  modport slave (
    input  block, rd_req, rd_only_i, empty,
    output rd_en, rd_only, grant, grant_id, grant_vld, rd_ack, burst_done, busy
  );
endinterface

// File: rtl/fifo_read_arb_rr_arbiter.sv
// Rotating-priority pick: first requester at or after ptr, wrapping to 0.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned CH_NUM = CH_NUM_DEF,
  parameter int unsigned CH_W   = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_NUM-1:0] gnt,
  output logic [CH_W-1:0]   gnt_id,
  output logic              gnt_vld
);

  logic [CH_W-1:0] cand;

  // Scan channels in priority order starting at ptr; keep the first hit.
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      cand = CH_W'((32'(ptr) + k) % CH_NUM);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
    gnt = gnt_vld ? CH_NUM'(idx2oh(CH_IDX_W'(gnt_id))) : '0;
  end

endmodule

// File: rtl/fifo_read_arb.sv
// Round-robin arbiter granting one channel at a time onto the FIFO read port,
// with burst limiting, empty/block gating and peek (non-popping) reads.
module fifo_read_arb
  import fifo_pkg::*;
#(
  parameter int unsigned CH_NUM    = CH_NUM_DEF,
  parameter int unsigned CH_W      = $clog2(CH_NUM),
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned BC_W      = $clog2(MAX_BURST + 1)
) (
  input logic             clk,
  input logic             rst,
  fifo_read_arb_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CH_NUM-1:0] grant_q, grant_d;
  logic [CH_W-1:0]   grant_id_q, grant_id_d;
  logic              grant_vld_q, grant_vld_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [BC_W-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              burst_done_q, burst_done_d;

  logic              stall_c;
  logic              owner_req_c;
  logic              owner_peek_c;
  logic              rd_en_c;
  logic              rd_only_c;
  logic              pop_c;
  logic [CH_W-1:0]   ptr_next_c;

  logic [CH_NUM-1:0] arb_gnt;
  logic [CH_W-1:0]   arb_id;
  logic              arb_vld;

  rr_arbiter #(
    .CH_NUM (CH_NUM),
    .CH_W   (CH_W)
  ) u_rr (
    .req     (bus.rd_req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_id  (arb_id),
    .gnt_vld (arb_vld)
  );

  // A block bit stalls immediately and, via busy, for one more cycle.
  assign stall_c      = (|bus.block) | busy_q;
  assign owner_req_c  = bus.rd_req[grant_id_q];
  assign owner_peek_c = bus.rd_only_i[grant_id_q];
  assign ptr_next_c   = (grant_id_q == CH_W'(CH_NUM - 1)) ? '0 : grant_id_q + CH_W'(1);

  // Next-state, beat gating, burst counting and release.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    grant_vld_d  = grant_vld_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    busy_d       = |bus.block;
    burst_done_d = 1'b0;
    rd_en_c      = 1'b0;
    rd_only_c    = 1'b0;
    pop_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!stall_c && arb_vld) begin
          state_d     = ST_OWN;
          grant_d     = arb_gnt;
          grant_id_d  = arb_id;
          grant_vld_d = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_OWN: begin
        rd_en_c   = owner_req_c & ~bus.empty & ~stall_c;
        rd_only_c = rd_en_c & owner_peek_c;
        pop_c     = rd_en_c & ~owner_peek_c;
        if (pop_c) cnt_d = cnt_q + BC_W'(1);
        if (!owner_req_c || (pop_c && cnt_q == BC_W'(MAX_BURST - 1))) begin
          state_d      = ST_IDLE;
          grant_d      = '0;
          grant_id_d   = '0;
          grant_vld_d  = 1'b0;
          ptr_d        = ptr_next_c;
          cnt_d        = '0;
          burst_done_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        grant_id_d  = '0;
        grant_vld_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and ownership registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grant_id_q   <= '0;
      grant_vld_q  <= 1'b0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      grant_vld_q  <= grant_vld_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign bus.rd_en      = rd_en_c;
  assign bus.rd_only    = rd_only_c;
  assign bus.rd_ack     = rd_en_c ? grant_q : '0;
  assign bus.grant      = grant_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.grant_vld  = grant_vld_q;
  assign bus.burst_done = burst_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fifo_read_arb.sv
// Self-checking bench for fifo_read_arb (CH_NUM=8, MAX_BURST=4).
module tb_fifo_read_arb;
  import fifo_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_read_arb_if #(.CH_NUM(N)) bus ();

  fifo_read_arb #(.CH_NUM(N), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: owner (-1 = none), pointer, popping beats, busy, done pulse.
  int m_owner, m_ptr, m_cnt;
  bit m_busy, m_done;
  bit e_rd_en, e_rd_only;

  typedef struct {
    logic [7:0] blk;
    logic [7:0] req;
    logic [7:0] ro;
    logic       emp;
    logic       exp_rd_en;
    logic [7:0] exp_grant;
    logic       exp_done;
    logic       exp_busy;
  } vec_t;

  vec_t tab[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic drive(input logic [7:0] blk, input logic [7:0] req,
                       input logic [7:0] ro, input logic emp);
    bus.block = blk; bus.rd_req = req; bus.rd_only_i = ro; bus.empty = emp;
  endtask

  // Compare every DUT output with the model's view of the current cycle.
  task automatic model_check();
    logic [7:0] eg;
    bit stall;
    stall = (|bus.block) || m_busy;
    eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    e_rd_en   = (m_owner >= 0) && bus.rd_req[m_owner] && !bus.empty && !stall;
    e_rd_only = e_rd_en && bus.rd_only_i[m_owner];
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("grant_vld", 32'(bus.grant_vld), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("grant_id", 32'(bus.grant_id), 32'(m_owner));
    chk("rd_en", 32'(bus.rd_en), 32'(e_rd_en));
    chk("rd_only", 32'(bus.rd_only), 32'(e_rd_only));
    chk("rd_ack", 32'(bus.rd_ack), e_rd_en ? 32'(eg) : 32'h0);
    chk("burst_done", 32'(bus.burst_done), 32'(m_done));
    chk("busy", 32'(bus.busy), 32'(m_busy));
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_next();
    bit stall;
    stall = (|bus.block) || m_busy;
    m_done = 0;
    if (m_owner < 0) begin
      if (!stall && (|bus.rd_req)) begin
        for (int k = 0; k < int'(N); k++) begin
          if (m_owner < 0 && bus.rd_req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_cnt = 0;
      end
    end else begin
      if (e_rd_en && !e_rd_only) m_cnt++;
      if (!bus.rd_req[m_owner] || m_cnt == int'(MB)) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt = 0;
        m_done = 1;
      end
    end
    m_busy = |bus.block;
  endtask

  task automatic step(input logic [7:0] blk, input logic [7:0] req,
                      input logic [7:0] ro, input logic emp);
    @(negedge clk);
    drive(blk, req, ro, emp);
    #1;
    model_check();
    model_next();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".grant"}, 32'(bus.grant), 32'h0);
    chk({tag, ".grant_vld"}, 32'(bus.grant_vld), 32'h0);
    chk({tag, ".rd_en"}, 32'(bus.rd_en), 32'h0);
    chk({tag, ".rd_only"}, 32'(bus.rd_only), 32'h0);
    chk({tag, ".rd_ack"}, 32'(bus.rd_ack), 32'h0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'h0);
    chk({tag, ".burst_done"}, 32'(bus.burst_done), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, peeks, ecnt, dones, ng;
    int gids[3];
    bit prev_vld;
    logic [7:0] blk, req, ro;
    logic emp;

    rst = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    model_reset();
    do_reset();

    // Table: single requester full burst, idle bubble, re-grant, then a block pulse.
    tab[0]  = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tab[1]  = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tab[2]  = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tab[3]  = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tab[4]  = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tab[5]  = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tab[6]  = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tab[7]  = '{8'h20, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
    tab[8]  = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
    tab[9]  = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tab[10] = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tab[11] = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tab[12] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tab[13] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tab[i].blk, tab[i].req, tab[i].ro, tab[i].emp);
      #1;
      chk($sformatf("tab%0d.rd_en", i), 32'(bus.rd_en), 32'(tab[i].exp_rd_en));
      chk($sformatf("tab%0d.grant", i), 32'(bus.grant), 32'(tab[i].exp_grant));
      chk($sformatf("tab%0d.rd_ack", i), 32'(bus.rd_ack),
          tab[i].exp_rd_en ? 32'(tab[i].exp_grant) : 32'h0);
      chk($sformatf("tab%0d.burst_done", i), 32'(bus.burst_done), 32'(tab[i].exp_done));
      chk($sformatf("tab%0d.busy", i), 32'(bus.busy), 32'(tab[i].exp_busy));
    end

    // Reset while a beat is in progress drops everything at once.
    do_reset();
    step(8'h00, 8'h01, 8'h00, 1'b0);
    @(negedge clk);
    drive(8'h00, 8'h01, 8'h00, 1'b0);
    #1;
    chk("midrst.pre_rd_en", 32'(bus.rd_en), 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    model_reset();

    // Two requesters 0 and 7: grants alternate 0,7,0 with 4 beats each.
    ng = 0; beats = 0; dones = 0; prev_vld = 0;
    for (int c = 0; c < 60 && dones < 3; c++) begin
      step(8'h00, 8'h81, 8'h00, 1'b0);
      if (bus.grant_vld && !prev_vld && ng < 3) begin
        gids[ng] = int'(oh2idx(32'(bus.grant)));
        ng++;
      end
      prev_vld = bus.grant_vld;
      if (bus.rd_en) beats++;
      if (bus.burst_done) dones++;
    end
    chk("alt.grants", 32'(ng), 32'd3);
    chk("alt.g0", 32'(gids[0]), 32'd0);
    chk("alt.g1", 32'(gids[1]), 32'd7);
    chk("alt.g2", 32'(gids[2]), 32'd0);
    chk("alt.beats", 32'(beats), 32'd12);

    // Channel 3 owns; FIFO empty for 3 cycles after 2 beats; burst still totals 4.
    do_reset();
    beats = 0; ecnt = 0; dones = 0;
    for (int c = 0; c < 40 && dones == 0; c++) begin
      emp = (beats == 2 && ecnt < 3);
      step(8'h00, 8'h08, 8'h00, emp);
      if (emp) begin
        ecnt++;
        chk("empty.hold_grant", 32'(bus.grant), 32'h08);
      end
      if (bus.rd_en) beats++;
      if (bus.burst_done) dones++;
    end
    chk("empty.cycles", 32'(ecnt), 32'd3);
    chk("empty.beats", 32'(beats), 32'd4);
    chk("empty.done", 32'(dones), 32'd1);

    // Channel 2 peeks twice, then pops 4: 6 reads, 2 of them peeks.
    do_reset();
    beats = 0; peeks = 0; dones = 0;
    for (int c = 0; c < 40 && dones == 0; c++) begin
      ro = (beats < 2) ? 8'h04 : 8'h00;
      step(8'h00, 8'h04, ro, 1'b0);
      if (bus.rd_en) beats++;
      if (bus.rd_only) peeks++;
      if (bus.burst_done) dones++;
    end
    chk("peek.beats", 32'(beats), 32'd6);
    chk("peek.peeks", 32'(peeks), 32'd2);
    chk("peek.done", 32'(dones), 32'd1);

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        blk = ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        req = 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 3) == 0) req = 8'($urandom);
        ro  = 8'($urandom) & 8'($urandom);
        emp = ($urandom_range(0, 3) == 0);
        step(blk, req, ro, emp);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
